sa_mode_sequencer: RTL and testbench
====================================

Name: sa_mode_sequencer

Overview:
- Parametrised successor to the systolic-array mode FSM.
- Decodes the host's load/write strobes into four operating modes: READ, WRITE, LOAD, MATMUL.
- Times LOAD and MATMUL phases with run-time programmable cycle budgets and raises a maskable, acknowledgeable interrupt to the PS on completion.
- Sits between the AXI-GPIO/PS interface and the array controller, and drives the status LEDs.

Parameters:
- CNT_W, 8, width of cycle counters and length inputs.
- LOAD_CYCLES_DEF, 9, load budget used when load_len_vld=0.
- MM_CYCLES_DEF, 24, matmul budget used when mm_len_vld=0.
- IRQ_PULSE, 0:
  - 0 = irq is a level that follows the sticky pending bit.
  - 1 = irq is a one-cycle pulse per completion.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- en  in  1  sequencer enable
- load  in  1  host mode strobe
- write  in  1  host mode strobe
- load_len  in  CNT_W  programmed load budget
- load_len_vld  in  1  1 = use load_len, 0 = use LOAD_CYCLES_DEF
- mm_len  in  CNT_W  programmed matmul budget
- mm_len_vld  in  1  1 = use mm_len, 0 = use MM_CYCLES_DEF
- irq_mask  in  1  1 = suppress irq output (the pending bit still sets)
- irq_ack  in  1  clears the pending bit
- int_to_ps  out  1  interrupt to the PS
- irq_pending  out  1  sticky completion flag
- done  out  1  phase-complete level (high in LOAD_DONE or MM_DONE)
- aborted  out  1  one-cycle pulse when a running phase is abandoned
- busy  out  1  high in LOAD_RUN or MM_RUN
- cycle_cnt  out  CNT_W  elapsed cycles of the current phase
- mode  out  2  registered mode: 0 = MATMUL, 1 = WRITE, 2 = LOAD, 3 = READ
- read_led, write_led, load_led, matmul_led  out  1  one-hot of registered mode

Behaviour:
- Reset (rst=0, asynchronous):
  - state = IDLE; cycle_cnt = 0; mode = 0.
  - All flags and LEDs = 0.
- Mode decode from {load, write}: 00 MATMUL, 01 WRITE, 10 LOAD, 11 READ. Sampled every edge while en=1.
- States: IDLE, READ, WRITE, LOAD_RUN, LOAD_DONE, MM_RUN, MM_DONE.
- en=0:
  - Next edge goes to IDLE; cycle_cnt = 0; LEDs = 0.
  - If a phase was running, aborted pulses.
  - irq_pending is held.
- Entry edge (decoded mode differs from the registered mode, or state=IDLE with en=1):
  - Enter READ, WRITE, LOAD_RUN or MM_RUN; mode and LEDs update on the same edge.
  - cycle_cnt = 0.
  - Budget latched: L = selected length, with L = 0 treated as 1. Length inputs are ignored after the entry edge.
- Run states:
  - cycle_cnt increments on each edge.
  - On the edge where cycle_cnt == L-1: go to *_DONE, cycle_cnt = L, raise an internal completion event.
  - So done rises exactly L edges after the entry edge.
- DONE states hold while the mode is unchanged; cycle_cnt is frozen at L. Re-running a phase requires a mode change.
- Mode change while in a RUN state:
  - aborted = 1 for one cycle.
  - No completion event, no irq.
  - Enter the new mode's state directly (no pass through IDLE).
- Mode change from a DONE state: no abort; done drops on the same edge.
- READ and WRITE: cycle_cnt = 0, no timing, no irq.
- Interrupt:
  - irq_pending sets on a completion event and clears on irq_ack.
  - Set and ack on the same edge: set wins.
  - IRQ_PULSE=0: int_to_ps = irq_pending & ~irq_mask, registered.
  - IRQ_PULSE=1: int_to_ps = completion event & ~irq_mask, one cycle, coincident with done rising.
- Counter width: L ≤ 2^CNT_W − 1; no wrap is possible because the counter stops at L.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package sa_pkg holds:
  - typedef mode_e (MATMUL, WRITE, LOAD, READ);
  - typedef seq_state_e (the 7 states);
  - the mode decode function.
- One sub-module, sa_phase_timer: latch budget, count, terminal-count strobe. It is instantiated once and shared by LOAD and MATMUL, since the two phases are mutually exclusive.

Test Plan:
- Reset release, then {load, write}=10, en=1, load_len_vld=0:
  - done rises 9 edges after the entry edge; cycle_cnt = 9.
  - irq_pending = 1 and int_to_ps = 1 (IRQ_PULSE=0, mask=0).
  - load_led = 1.
- MATMUL with mm_len=5, mm_len_vld=1, IRQ_PULSE=1:
  - int_to_ps is high for exactly 1 cycle, 5 edges after entry.
  - irq_pending stays 1 until irq_ack, then 0.
- MATMUL running, cycle_cnt=10, switch to WRITE:
  - aborted pulses once; irq_pending stays 0; write_led = 1; cycle_cnt = 0.
- mm_len=0, mm_len_vld=1: done rises 1 edge after entry.
- irq_mask=1 during completion: irq_pending = 1, int_to_ps = 0. Clearing the mask with pending still set gives int_to_ps = 1 next cycle.
- Assert rst (low) mid-LOAD at cycle_cnt=4: all outputs read 0 immediately, without waiting for a clock edge. After release with load still held, the sequencer restarts from cycle_cnt = 0.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared types for the systolic-array mode sequencer.
// Holds the mode and state encodings and the host strobe decode.
package sa_pkg;

    typedef enum logic [1:0] {
        MATMUL = 2'd0,
        WRITE  = 2'd1,
        LOAD   = 2'd2,
        READ   = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_READ      = 3'd1,
        S_WRITE     = 3'd2,
        S_LOAD_RUN  = 3'd3,
        S_LOAD_DONE = 3'd4,
        S_MM_RUN    = 3'd5,
        S_MM_DONE   = 3'd6
    } seq_state_e;

    // {load, write} maps straight onto the mode encoding
    function automatic mode_e decode_mode(input logic ld, input logic wr);
        return mode_e'({ld, wr});
    endfunction

endpackage

// File: rtl/sa_phase_timer.sv
// Phase timer shared by LOAD and MATMUL.
// Latches the budget on start, counts on step, flags the last cycle.
module sa_phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clear,
    input  logic             step,
    input  logic [CNT_W-1:0] len,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    logic [CNT_W-1:0] budget;

    // A zero budget would never terminate, so it runs as one cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            budget <= CNT_W'(1);
            cnt    <= '0;
        end else if (clear) begin
            cnt    <= '0;
        end else if (start) begin
            budget <= (len == '0) ? CNT_W'(1) : len;
            cnt    <= '0;
        end else if (step) begin
            cnt    <= cnt + 1'b1;
        end
    end

    assign last = (cnt == budget - 1'b1);

endmodule

// File: rtl/sa_mode_sequencer.sv
// Systolic-array mode sequencer: decodes host strobes into modes,
// times LOAD/MATMUL phases and raises a completion interrupt.
module sa_mode_sequencer #(
    parameter int CNT_W           = 8,
    parameter int LOAD_CYCLES_DEF = 9,
    parameter int MM_CYCLES_DEF   = 24,
    parameter int IRQ_PULSE       = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic             write,
    input  logic [CNT_W-1:0] load_len,
    input  logic             load_len_vld,
    input  logic [CNT_W-1:0] mm_len,
    input  logic             mm_len_vld,
    input  logic             irq_mask,
    input  logic             irq_ack,
    output logic             int_to_ps,
    output logic             irq_pending,
    output logic             done,
    output logic             aborted,
    output logic             busy,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [1:0]       mode,
    output logic             read_led,
    output logic             write_led,
    output logic             load_led,
    output logic             matmul_led
);

    import sa_pkg::*;

    seq_state_e       state_q, state_d;
    mode_e            mode_q, mode_d, dmode;
    logic             pend_q, pend_d;
    logic             int_q, int_d;
    logic             abort_q, abort_d;
    logic             running;
    logic             start, clear, step, last, complete;
    logic [CNT_W-1:0] sel_len;

    assign dmode   = decode_mode(load, write);
    assign running = (state_q == S_LOAD_RUN) || (state_q == S_MM_RUN);

    // Budget for the phase being entered, chosen by the incoming mode
    always_comb begin
        sel_len = '0;
        if (dmode == LOAD)
            sel_len = load_len_vld ? load_len : CNT_W'(LOAD_CYCLES_DEF);
        else
            sel_len = mm_len_vld ? mm_len : CNT_W'(MM_CYCLES_DEF);
    end

    // Next state, timer control, abort and interrupt decisions
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        start    = 1'b0;
        clear    = 1'b0;
        step     = 1'b0;
        complete = 1'b0;
        abort_d  = 1'b0;
        if (!en) begin
            state_d = S_IDLE;
            clear   = 1'b1;
            abort_d = running;
        end else if (state_q == S_IDLE || dmode != mode_q) begin
            abort_d = running;
            mode_d  = dmode;
            unique case (dmode)
                READ: begin
                    state_d = S_READ;
                    clear   = 1'b1;
                end
                WRITE: begin
                    state_d = S_WRITE;
                    clear   = 1'b1;
                end
                LOAD: begin
                    state_d = S_LOAD_RUN;
                    start   = 1'b1;
                end
                MATMUL: begin
                    state_d = S_MM_RUN;
                    start   = 1'b1;
                end
            endcase
        end else if (running) begin
            step = 1'b1;
            if (last) begin
                complete = 1'b1;
                state_d  = (state_q == S_LOAD_RUN) ? S_LOAD_DONE
                                                   : S_MM_DONE;
            end
        end
        pend_d = complete | (pend_q & ~irq_ack);
        if (IRQ_PULSE != 0)
            int_d = complete & ~irq_mask;
        else
            int_d = pend_d & ~irq_mask;
    end

    // State, mode and interrupt registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            mode_q  <= MATMUL;
            pend_q  <= 1'b0;
            int_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            pend_q  <= pend_d;
            int_q   <= int_d;
            abort_q <= abort_d;
        end
    end

    sa_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .clear (clear),
        .step  (step),
        .len   (sel_len),
        .cnt   (cycle_cnt),
        .last  (last)
    );

    assign int_to_ps   = int_q;
    assign irq_pending = pend_q;
    assign aborted     = abort_q;
    assign mode        = mode_q;
    assign busy        = running;
    assign done        = (state_q == S_LOAD_DONE) || (state_q == S_MM_DONE);
    assign read_led    = (state_q == S_READ);
    assign write_led   = (state_q == S_WRITE);
    assign load_led    = (state_q == S_LOAD_RUN) || (state_q == S_LOAD_DONE);
    assign matmul_led  = (state_q == S_MM_RUN) || (state_q == S_MM_DONE);

endmodule

// File: tb/tb_sa_mode_sequencer.sv
// Bench for sa_mode_sequencer: level-irq and pulse-irq instances
// driven in parallel, checked against a phase-level model.
module tb_sa_mode_sequencer;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en = 1'b0, load = 1'b0, write = 1'b0;
    logic load_len_vld = 1'b0, mm_len_vld = 1'b0;
    logic irq_mask = 1'b0, irq_ack = 1'b0;
    logic [W-1:0] load_len = '0, mm_len = '0;

    logic int0, pend0, done0, abrt0, busy0, rl0, wl0, ll0, ml0;
    logic int1, pend1, done1, abrt1, busy1, rl1, wl1, ll1, ml1;
    logic [W-1:0] cnt0, cnt1;
    logic [1:0] mode0, mode1;

    int n_vec = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    sa_mode_sequencer #(.CNT_W(W), .IRQ_PULSE(0)) u0 (
        .clk(clk), .rst(rst), .en(en), .load(load), .write(write),
        .load_len(load_len), .load_len_vld(load_len_vld),
        .mm_len(mm_len), .mm_len_vld(mm_len_vld),
        .irq_mask(irq_mask), .irq_ack(irq_ack),
        .int_to_ps(int0), .irq_pending(pend0), .done(done0),
        .aborted(abrt0), .busy(busy0), .cycle_cnt(cnt0), .mode(mode0),
        .read_led(rl0), .write_led(wl0), .load_led(ll0), .matmul_led(ml0)
    );

    sa_mode_sequencer #(.CNT_W(W), .IRQ_PULSE(1)) u1 (
        .clk(clk), .rst(rst), .en(en), .load(load), .write(write),
        .load_len(load_len), .load_len_vld(load_len_vld),
        .mm_len(mm_len), .mm_len_vld(mm_len_vld),
        .irq_mask(irq_mask), .irq_ack(irq_ack),
        .int_to_ps(int1), .irq_pending(pend1), .done(done1),
        .aborted(abrt1), .busy(busy1), .cycle_cnt(cnt1), .mode(mode1),
        .read_led(rl1), .write_led(wl1), .load_led(ll1), .matmul_led(ml1)
    );

    // Phase-level reference model
    bit m_active, m_timed, m_done, m_pend, m_int0, m_int1, m_abort;
    int m_mode, m_cnt, m_len;

    task automatic model_reset();
        m_active = 0; m_timed = 0; m_done = 0; m_pend = 0;
        m_int0 = 0; m_int1 = 0; m_abort = 0;
        m_mode = 0; m_cnt = 0; m_len = 1;
    endtask

    task automatic model_step();
        bit ev;
        int dm;
        ev = 0;
        m_abort = 0;
        if (!en) begin
            m_abort = m_active && m_timed && !m_done;
            m_active = 0;
            m_cnt = 0;
        end else begin
            dm = {30'd0, load, write};
            if (!m_active || dm != m_mode) begin
                m_abort = m_active && m_timed && !m_done;
                m_active = 1;
                m_mode = dm;
                m_cnt = 0;
                m_done = 0;
                m_timed = (dm == 0) || (dm == 2);
                if (dm == 2) m_len = load_len_vld ? int'(load_len) : 9;
                else m_len = mm_len_vld ? int'(mm_len) : 24;
                if (m_len == 0) m_len = 1;
            end else if (m_timed && !m_done) begin
                m_cnt++;
                if (m_cnt == m_len) begin
                    m_done = 1;
                    ev = 1;
                end
            end
        end
        m_pend = ev || (m_pend && !irq_ack);
        m_int0 = m_pend && !irq_mask;
        m_int1 = ev && !irq_mask;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int led_exp();
        if (!m_active) return 0;
        case (m_mode)
            3: return 8;
            1: return 4;
            2: return 2;
            default: return 1;
        endcase
    endfunction

    task automatic check_all();
        int busy_e, done_e;
        busy_e = (m_active && m_timed && !m_done) ? 1 : 0;
        done_e = (m_active && m_timed && m_done) ? 1 : 0;
        n_vec++;
        chk("cnt0", int'(cnt0), m_cnt);
        chk("cnt1", int'(cnt1), m_cnt);
        chk("mode0", int'(mode0), m_mode);
        chk("mode1", int'(mode1), m_mode);
        chk("busy0", int'(busy0), busy_e);
        chk("busy1", int'(busy1), busy_e);
        chk("done0", int'(done0), done_e);
        chk("done1", int'(done1), done_e);
        chk("abort0", int'(abrt0), int'(m_abort));
        chk("abort1", int'(abrt1), int'(m_abort));
        chk("pend0", int'(pend0), int'(m_pend));
        chk("pend1", int'(pend1), int'(m_pend));
        chk("irq_level", int'(int0), int'(m_int0));
        chk("irq_pulse", int'(int1), int'(m_int1));
        chk("leds0", int'({rl0, wl0, ll0, ml0}), led_exp());
        chk("leds1", int'({rl1, wl1, ll1, ml1}), led_exp());
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    typedef struct {
        bit en, ld, wr, ack;
        int cnt;
        bit done, busy, pend, irq;
        bit [3:0] led;
    } vec_t;

    function automatic vec_t mk(bit e, bit l, bit w, bit a, int c,
                                bit d, bit b, bit p, bit i, bit [3:0] led);
        vec_t v;
        v.en = e; v.ld = l; v.wr = w; v.ack = a; v.cnt = c;
        v.done = d; v.busy = b; v.pend = p; v.irq = i; v.led = led;
        return v;
    endfunction

    initial begin
        vec_t tv[12];
        int hits, at;

        // LOAD with default budget of 9, then hold, then ack
        for (int i = 0; i < 9; i++)
            tv[i] = mk(1, 1, 0, 0, i, 0, 1, 0, 0, 4'b0010);
        tv[9]  = mk(1, 1, 0, 0, 9, 1, 0, 1, 1, 4'b0010);
        tv[10] = mk(1, 1, 0, 0, 9, 1, 0, 1, 1, 4'b0010);
        tv[11] = mk(1, 1, 0, 1, 9, 1, 0, 0, 0, 4'b0010);

        model_reset();
        #1;
        check_all();
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;

        foreach (tv[i]) begin
            en = tv[i].en; load = tv[i].ld;
            write = tv[i].wr; irq_ack = tv[i].ack;
            tick();
            n_vec++;
            chk("tab_cnt", int'(cnt0), tv[i].cnt);
            chk("tab_done", int'(done0), int'(tv[i].done));
            chk("tab_busy", int'(busy0), int'(tv[i].busy));
            chk("tab_pend", int'(pend0), int'(tv[i].pend));
            chk("tab_irq", int'(int0), int'(tv[i].irq));
            chk("tab_led", int'({rl0, wl0, ll0, ml0}), int'(tv[i].led));
        end

        // MATMUL of 5 cycles: single irq pulse on the 5th edge
        irq_ack = 0; load = 0; write = 0;
        mm_len = 8'd5; mm_len_vld = 1;
        tick();
        hits = 0; at = -1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (int1) begin
                hits++;
                at = k;
            end
        end
        chk("mm_pulse_count", hits, 1);
        chk("mm_pulse_edge", at, 5);
        chk("mm_pend_held", int'(pend1), 1);
        irq_ack = 1;
        tick();
        irq_ack = 0;
        chk("mm_pend_acked", int'(pend1), 0);

        // Abort a running MATMUL at cycle 10 by switching to WRITE
        write = 1;
        tick();
        write = 0; mm_len = 8'd20;
        tick();
        repeat (10) tick();
        chk("abort_pre_cnt", int'(cnt0), 10);
        write = 1;
        tick();
        chk("abort_pulse", int'(abrt0), 1);
        chk("abort_no_irq", int'(pend0), 0);
        chk("abort_wled", int'(wl0), 1);
        chk("abort_cnt", int'(cnt0), 0);
        tick();
        chk("abort_once", int'(abrt0), 0);

        // Zero budget behaves as one cycle
        write = 0; mm_len = 8'd0;
        tick();
        tick();
        chk("zero_len_done", int'(done0), 1);
        chk("zero_len_cnt", int'(cnt0), 1);

        // Masked completion, then unmask with pending set
        irq_ack = 1; write = 1;
        tick();
        irq_ack = 0; irq_mask = 1;
        load = 1; write = 0; load_len = 8'd3; load_len_vld = 1;
        tick();
        repeat (3) tick();
        chk("mask_pend", int'(pend0), 1);
        chk("mask_irq", int'(int0), 0);
        irq_mask = 0;
        tick();
        chk("unmask_irq", int'(int0), 1);

        // Asynchronous reset in the middle of LOAD
        load_len_vld = 0; load = 0; write = 1;
        tick();
        load = 1; write = 0;
        tick();
        repeat (4) tick();
        chk("rst_pre_cnt", int'(cnt0), 4);
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        #1 rst = 1'b1;
        tick();
        chk("rst_restart_cnt", int'(cnt0), 0);
        chk("rst_restart_busy", int'(busy0), 1);

        // Randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            en = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 9) == 0) begin
                load = 1'($urandom);
                write = 1'($urandom);
            end
            load_len = 8'($urandom_range(0, 20));
            mm_len = 8'($urandom_range(0, 30));
            load_len_vld = 1'($urandom);
            mm_len_vld = 1'($urandom);
            irq_ack = ($urandom_range(0, 7) == 0);
            irq_mask = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
